// File: rtl/adc_sample_fetcher.sv
// ADC req/rdy/dat initiator: resets the ADC, fetches samples one request at a time,
// and buffers them in a FIFO that is drained over a valid/ready stream.
module adc_sample_fetcher #(
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       FIFO_DEPTH = 16,
  parameter int unsigned       REQ_HI     = 2,
  parameter int unsigned       TIMEOUT    = 255,
  parameter logic [DATA_W-1:0] END_MARK   = DATA_W'(16'h00FF)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [15:0]                 num_samples,
  input  logic                        ends_on_mark,
  output logic                        adc_req,
  output logic                        adc_rst,
  input  logic                        adc_rdy,
  input  logic [DATA_W-1:0]           adc_dat,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout_err
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned PH_W  = $clog2(REQ_HI + 2);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1) + 1;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_ARST, S_GAP, S_ISSUE, S_REQ, S_WAIT, S_CAP, S_FIN
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [PH_W-1:0]    r_phase;
  logic [TMO_W-1:0]   r_tmo;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_num;
  logic               r_mark_en;
  logic               r_rdy_meta;
  logic               r_rdy_s;
  logic               r_adc_req;
  logic               r_adc_rst;
  logic               r_busy;
  logic               r_done;
  logic               r_timeout_err;
  logic               w_adc_req_d;
  logic               w_adc_rst_d;
  logic               w_busy_d;
  logic               w_done_d;

  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic [PTR_W-1:0]   w_rd_next;
  logic [LVL_W-1:0]   w_level_next;
  logic [DATA_W-1:0]  w_head_next;

  logic               w_fifo_full;
  logic               w_mark_hit;
  logic [CNT_W-1:0]   w_count_inc;
  logic               w_last;
  logic               w_accept;
  logic               w_timeout;
  logic               w_push;
  logic               w_pop;

  assign w_fifo_full = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_mark_hit  = r_mark_en && (adc_dat == END_MARK);
  assign w_count_inc = r_count + CNT_W'(1);
  assign w_last      = (r_num != '0) && (w_count_inc == r_num);
  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_timeout   = (r_state == S_WAIT) && !r_rdy_s && (r_tmo == TMO_W'(TIMEOUT));
  assign w_push      = (r_state == S_CAP) && !w_mark_hit;
  assign w_pop       = r_out_valid && out_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; rdy is only seen through the synchronizer
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_ARST;
      S_ARST:  if (r_phase == PH_W'(1)) w_next_state = S_GAP;
      S_GAP:   w_next_state = S_ISSUE;
      S_ISSUE: if (!w_fifo_full) w_next_state = S_REQ;
      S_REQ:   if (r_phase == PH_W'(REQ_HI - 1)) w_next_state = S_WAIT;
      S_WAIT: begin
        if (r_rdy_s)                           w_next_state = S_CAP;
        else if (r_tmo == TMO_W'(TIMEOUT))     w_next_state = S_IDLE;
      end
      S_CAP:   w_next_state = (w_mark_hit || w_last) ? S_FIN : S_ISSUE;
      S_FIN:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode from the next state so registered outputs line up with the state
  always_comb begin
    w_adc_req_d = 1'b0;
    w_adc_rst_d = 1'b0;
    w_busy_d    = 1'b0;
    w_done_d    = 1'b0;
    w_adc_req_d = (w_next_state == S_REQ);
    w_adc_rst_d = (w_next_state == S_ARST);
    w_busy_d    = (w_next_state != S_IDLE);
    w_done_d    = (w_next_state == S_FIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_adc_req     <= 1'b0;
      r_adc_rst     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_rdy_meta    <= 1'b0;
      r_rdy_s       <= 1'b0;
      r_phase       <= '0;
      r_tmo         <= '0;
      r_count       <= '0;
      r_num         <= '0;
      r_mark_en     <= 1'b0;
    end else begin
      r_adc_req  <= w_adc_req_d;
      r_adc_rst  <= w_adc_rst_d;
      r_busy     <= w_busy_d;
      r_done     <= w_done_d;
      r_rdy_meta <= adc_rdy;
      r_rdy_s    <= r_rdy_meta;
      // Phase counter restarts on every state change
      r_phase    <= (w_next_state == r_state) ? PH_W'(r_phase + 1'b1) : '0;
      r_tmo      <= ((r_state == S_WAIT) && (w_next_state == S_WAIT)) ?
                    TMO_W'(r_tmo + 1'b1) : '0;
      if (w_accept) begin
        r_num     <= num_samples;
        r_mark_en <= ends_on_mark;
        r_count   <= '0;
      end else if (w_push) begin
        r_count   <= w_count_inc;
      end
      if (w_accept)       r_timeout_err <= 1'b0;
      else if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  // FIFO next-state: level, read pointer and the registered head word
  always_comb begin
    w_level_next = r_level;
    if (w_push && !w_pop)      w_level_next = LVL_W'(r_level + 1'b1);
    else if (!w_push && w_pop) w_level_next = LVL_W'(r_level - 1'b1);
    w_rd_next   = w_pop ? PTR_W'(r_rd_ptr + 1'b1) : r_rd_ptr;
    w_head_next = r_out_data;
    if (w_push && ((r_level == '0) || ((r_level == LVL_W'(1)) && w_pop)))
      w_head_next = adc_dat;
    else if (w_level_next != '0)
      w_head_next = r_mem[w_rd_next];
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= adc_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
      r_rd_ptr    <= w_rd_next;
      r_level     <= w_level_next;
      r_out_valid <= (w_level_next != '0);
      r_out_data  <= w_head_next;
    end
  end

  assign adc_req     = r_adc_req;
  assign adc_rst     = r_adc_rst;
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout_err = r_timeout_err;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign fifo_level  = r_level;

endmodule

// File: tb/tb_adc_sample_fetcher.sv
// Directed bench for adc_sample_fetcher with a behavioural ADC that answers each request.
module tb_adc_sample_fetcher;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned REQ_HI     = 2;
  localparam int unsigned TIMEOUT    = 255;
  localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [15:0]       num_samples = '0;
  logic              ends_on_mark = 1'b0;
  logic              out_ready = 1'b0;
  logic              adc_rdy = 1'b0;
  logic [DATA_W-1:0] adc_dat = '0;
  logic              adc_req, adc_rst, out_valid, busy, done, timeout_err;
  logic [DATA_W-1:0] out_data;
  logic [LVL_W-1:0]  fifo_level;

  int errors = 0;
  int checks = 0;

  logic              adc_respond = 1'b1;
  logic [DATA_W-1:0] vals[$];
  logic [DATA_W-1:0] got[$];
  int                done_cnt, busy_cycles, arst_cycles, req_pulses, bad_width, hi_len;
  logic              req_q = 1'b0;

  adc_sample_fetcher #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .REQ_HI(REQ_HI), .TIMEOUT(TIMEOUT),
    .END_MARK(16'h00FF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .ends_on_mark(ends_on_mark), .adc_req(adc_req), .adc_rst(adc_rst),
    .adc_rdy(adc_rdy), .adc_dat(adc_dat), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .fifo_level(fifo_level),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // ADC model: drop rdy on request, present data and raise rdy a few cycles later
  always @(posedge adc_req) begin
    adc_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (adc_respond && vals.size() > 0) begin
      adc_dat = vals.pop_front();
      adc_rdy = 1'b1;
    end
  end

  // Observation of stream output and handshake outputs
  always @(negedge clk) begin
    #1;
    if (out_valid && out_ready) got.push_back(out_data);
    if (done)    done_cnt++;
    if (busy)    busy_cycles++;
    if (adc_rst) arst_cycles++;
    if (adc_req && !req_q) req_pulses++;
    if (adc_req) hi_len++;
    else begin
      if (req_q && hi_len != int'(REQ_HI)) bad_width++;
      hi_len = 0;
    end
    req_q = adc_req;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [DATA_W-1:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 'x;
  endfunction

  task automatic clear_stats();
    got.delete();
    done_cnt = 0; busy_cycles = 0; arst_cycles = 0; req_pulses = 0; bad_width = 0;
  endtask

  task automatic do_start(input logic [15:0] n, input logic mark);
    @(negedge clk);
    num_samples = n; ends_on_mark = mark; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, budget);
    end
  endtask

  task automatic wait_reqs(input int target, input int budget);
    int n = 0;
    while (req_pulses < target && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    checks++;
    if (req_pulses < target) begin
      errors++;
      $display("FAIL wait_reqs: req_pulses=%0d, required %0d", req_pulses, target);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 7;
    if (adc_req !== 1'b0)     begin errors++; $display("FAIL rst_adc_req: %b, required 0", adc_req); end
    if (adc_rst !== 1'b0)     begin errors++; $display("FAIL rst_adc_rst: %b, required 0", adc_rst); end
    if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy: %b, required 0", busy); end
    if (done !== 1'b0)        begin errors++; $display("FAIL rst_done: %b, required 0", done); end
    if (out_valid !== 1'b0)   begin errors++; $display("FAIL rst_out_valid: %b, required 0", out_valid); end
    if (fifo_level !== '0)    begin errors++; $display("FAIL rst_level: %0d, required 0", fifo_level); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_tmo: %b, required 0", timeout_err); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    clear_stats();
    out_ready = 1'b1; adc_respond = 1'b1;
    vals = '{16'd10, 16'd20, 16'd30};
    do_start(16'd3, 1'b0);
    wait_idle(300);
    checks += 8;
    if (got.size() != 3)        begin errors++; $display("FAIL basic_count: %0d words, required 3", got.size()); end
    if (got_at(0) !== 16'd10)   begin errors++; $display("FAIL basic_w0: %0d, required 10", got_at(0)); end
    if (got_at(1) !== 16'd20)   begin errors++; $display("FAIL basic_w1: %0d, required 20", got_at(1)); end
    if (got_at(2) !== 16'd30)   begin errors++; $display("FAIL basic_w2: %0d, required 30", got_at(2)); end
    if (done_cnt != 1)          begin errors++; $display("FAIL basic_done: %0d pulses, required 1", done_cnt); end
    if (req_pulses != 3)        begin errors++; $display("FAIL basic_reqs: %0d, required 3", req_pulses); end
    if (bad_width != 0)         begin errors++; $display("FAIL basic_req_width: %0d bad pulses, required 0", bad_width); end
    if (arst_cycles != 2)       begin errors++; $display("FAIL basic_adc_rst: %0d cycles, required 2", arst_cycles); end
  endtask

  task automatic test_end_mark();
    clear_stats();
    out_ready = 1'b1;
    vals = '{16'd5, 16'd6, 16'h00FF};
    do_start(16'd0, 1'b1);
    wait_idle(300);
    checks += 5;
    if (got.size() != 2)      begin errors++; $display("FAIL mark_count: %0d words, required 2", got.size()); end
    if (got_at(0) !== 16'd5)  begin errors++; $display("FAIL mark_w0: %0d, required 5", got_at(0)); end
    if (got_at(1) !== 16'd6)  begin errors++; $display("FAIL mark_w1: %0d, required 6", got_at(1)); end
    if (done_cnt != 1)        begin errors++; $display("FAIL mark_done: %0d pulses, required 1", done_cnt); end
    if (fifo_level !== '0)    begin errors++; $display("FAIL mark_level: %0d, required 0", fifo_level); end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    clear_stats();
    out_ready = 1'b0;
    vals.delete();
    for (int i = 0; i < 20; i++) vals.push_back(DATA_W'(100 + i));
    do_start(16'd20, 1'b0);
    wait_reqs(16, 1000);
    repeat (60) @(negedge clk);
    checks += 3;
    if (req_pulses != 16)             begin errors++; $display("FAIL bp_stall_reqs: %0d, required 16", req_pulses); end
    if (fifo_level !== LVL_W'(16))    begin errors++; $display("FAIL bp_level: %0d, required 16", fifo_level); end
    if (busy !== 1'b1)                begin errors++; $display("FAIL bp_busy: %b, required 1", busy); end
    out_ready = 1'b1;
    wait_idle(500);
    for (int i = 0; i < 20; i++) if (got_at(i) !== DATA_W'(100 + i)) bad++;
    checks += 4;
    if (got.size() != 20)  begin errors++; $display("FAIL bp_count: %0d words, required 20", got.size()); end
    if (bad != 0)          begin errors++; $display("FAIL bp_order: %0d wrong words, required 0", bad); end
    if (req_pulses != 20)  begin errors++; $display("FAIL bp_total_reqs: %0d, required 20", req_pulses); end
    if (done_cnt != 1)     begin errors++; $display("FAIL bp_done: %0d pulses, required 1", done_cnt); end
  endtask

  task automatic test_timeout();
    clear_stats();
    adc_respond = 1'b0;
    vals.delete();
    do_start(16'd2, 1'b0);
    wait_idle(600);
    // ARST 2 + GAP 1 + ISSUE 1 + REQ 2 + WAIT (TIMEOUT+1)
    checks += 4;
    if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_flag: %b, required 1", timeout_err); end
    if (done_cnt != 0)        begin errors++; $display("FAIL tmo_done: %0d pulses, required 0", done_cnt); end
    if (busy_cycles != 262)   begin errors++; $display("FAIL tmo_duration: busy %0d cycles, required 262", busy_cycles); end
    if (req_pulses != 1)      begin errors++; $display("FAIL tmo_reqs: %0d, required 1", req_pulses); end
    clear_stats();
    adc_respond = 1'b1;
    vals = '{16'd7};
    do_start(16'd1, 1'b0);
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_clear: %b, required 0", timeout_err); end
    wait_idle(300);
    checks += 2;
    if (got_at(0) !== 16'd7 || got.size() != 1)
      begin errors++; $display("FAIL tmo_rerun_data: %0d (%0d words), required 7 (1 word)", got_at(0), got.size()); end
    if (done_cnt != 1) begin errors++; $display("FAIL tmo_rerun_done: %0d pulses, required 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    out_ready = 1'b0; adc_respond = 1'b1;
    vals = '{16'd1, 16'd2};
    do_start(16'd2, 1'b0);
    wait_idle(300);
    checks++;
    if (fifo_level !== LVL_W'(2)) begin errors++; $display("FAIL rmid_prefill: %0d, required 2", fifo_level); end
    adc_respond = 1'b0;
    do_start(16'd1, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 5;
    if (busy !== 1'b0)        begin errors++; $display("FAIL rmid_busy: %b, required 0", busy); end
    if (fifo_level !== '0)    begin errors++; $display("FAIL rmid_level: %0d, required 0", fifo_level); end
    if (out_valid !== 1'b0)   begin errors++; $display("FAIL rmid_valid: %b, required 0", out_valid); end
    if (adc_req !== 1'b0)     begin errors++; $display("FAIL rmid_req: %b, required 0", adc_req); end
    if (out_data !== '0)      begin errors++; $display("FAIL rmid_data: %0d, required 0", out_data); end
    @(negedge clk);
    rst = 1'b0;
    clear_stats();
    out_ready = 1'b1; adc_respond = 1'b1;
    vals = '{16'd42};
    do_start(16'd1, 1'b0);
    wait_idle(300);
    checks += 3;
    if (got_at(0) !== 16'd42 || got.size() != 1)
      begin errors++; $display("FAIL rmid_rerun_data: %0d (%0d words), required 42 (1 word)", got_at(0), got.size()); end
    if (done_cnt != 1)        begin errors++; $display("FAIL rmid_rerun_done: %0d pulses, required 1", done_cnt); end
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL rmid_rerun_tmo: %b, required 0", timeout_err); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    clear_stats();
    out_ready = 1'b0; adc_respond = 1'b1;
    vals = '{16'd50, 16'd51};
    do_start(16'd2, 1'b0);
    wait_reqs(2, 300);
    while (!adc_rdy && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    // rdy_s after two edges, CAP after the third, push on the fourth
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (fifo_level !== LVL_W'(1)) begin errors++; $display("FAIL b2b_pre_level: %0d, required 1", fifo_level); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks += 2;
    if (fifo_level !== LVL_W'(1)) begin errors++; $display("FAIL b2b_level: %0d, required 1", fifo_level); end
    if (out_data !== 16'd51)      begin errors++; $display("FAIL b2b_head: %0d, required 51", out_data); end
    wait_idle(100);
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    checks += 3;
    if (got.size() != 2)                          begin errors++; $display("FAIL b2b_count: %0d words, required 2", got.size()); end
    if (got_at(0) !== 16'd50 || got_at(1) !== 16'd51)
      begin errors++; $display("FAIL b2b_order: %0d,%0d, required 50,51", got_at(0), got_at(1)); end
    if (done_cnt != 1)                            begin errors++; $display("FAIL b2b_done: %0d pulses, required 1", done_cnt); end
  endtask

  initial begin
    clear_stats();
    hi_len = 0;
    test_reset();
    test_basic();
    test_end_mark();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
